// File: rtl/param_control_unit.sv
// Multi-cycle control unit: fetch handshake -> decode -> execute -> writeback/memory wait.
// Optional macro MEM_TIMEOUT_EN adds a memory-wait timeout (err pulse, abort to FETCH).
module param_control_unit #(
    parameter int INST_W   = 16,
    parameter int OPC_W    = 4,
    parameter int REG_AW   = 4,
    parameter int ALU_OP_W = 5,
    parameter int OFFS_W   = 10,
    parameter int MEM_TO   = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [INST_W-1:0]   inst,
    input  logic                inst_valid,
    output logic                inst_ready,
    input  logic                stall,
    input  logic                zero_flag,
    input  logic                mem_ack,
    output logic [REG_AW-1:0]   src_reg,
    output logic [REG_AW-1:0]   dst_reg,
    output logic [REG_AW-1:0]   wr_reg,
    output logic                wr_en,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                mem_rd,
    output logic                mem_wr,
    output logic                pc_inc,
    output logic                en_pc_2,
    output logic                branch_en,
    output logic [OFFS_W-1:0]   pc_offset,
    output logic [2:0]          fsm_state,
    output logic                err
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_WB     = 3'd3,
        S_MEMW   = 3'd4
    } state_t;

    localparam int N = 2 ** OPC_W;
    localparam logic [OPC_W-1:0] OPC_LOAD   = OPC_W'(N - 4);
    localparam logic [OPC_W-1:0] OPC_STORE  = OPC_W'(N - 3);
    localparam logic [OPC_W-1:0] OPC_BRANCH = OPC_W'(N - 2);
    localparam logic [OPC_W-1:0] OPC_JUMP   = OPC_W'(N - 1);

    state_t state, next_state;
    logic [INST_W-1:0] ir;
    logic [OPC_W-1:0]  opc;
    logic is_nop, is_alu, is_load, is_store, is_branch, is_jump;
    logic accept, timeout, pc_step, taken;

    assign opc       = ir[INST_W-1 -: OPC_W];
    assign is_nop    = (opc == '0);
    assign is_load   = (opc == OPC_LOAD);
    assign is_store  = (opc == OPC_STORE);
    assign is_branch = (opc == OPC_BRANCH);
    assign is_jump   = (opc == OPC_JUMP);
    assign is_alu    = !is_nop && (opc < OPC_LOAD);

    // Handshake: an instruction transfers in any cycle where inst_valid && inst_ready;
    // inst_ready is only offered in FETCH and never while stalled.
    assign accept = (state == S_FETCH) && inst_valid && !stall;

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = ($clog2(MEM_TO + 1) > 4) ? $clog2(MEM_TO + 1) : 4;
    logic [CNT_W-1:0] mem_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            mem_cnt <= '0;
        else if (state == S_MEMW)
            mem_cnt <= mem_cnt + 1'b1;
        else
            mem_cnt <= '0;
    end

    // Fires in the last permitted MEMW cycle; a simultaneous mem_ack takes precedence.
    assign timeout = (state == S_MEMW) && !mem_ack && (mem_cnt == CNT_W'(MEM_TO - 1));
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_FETCH;
            ir    <= '0;
        end else begin
            state <= next_state;
            if (accept)
                ir <= inst;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_FETCH:  if (accept) next_state = S_DECODE;
            S_DECODE: begin
                if (stall)       next_state = S_DECODE;
                else if (is_nop) next_state = S_FETCH;
                else             next_state = S_EXEC;
            end
            S_EXEC: begin
                if (is_alu)                    next_state = S_WB;
                else if (is_load || is_store)  next_state = S_MEMW;
                else                           next_state = S_FETCH;
            end
            S_MEMW: begin
                if (mem_ack)      next_state = is_load ? S_WB : S_FETCH;
                else if (timeout) next_state = S_FETCH;
                else              next_state = S_MEMW;
            end
            S_WB:     next_state = S_FETCH;
            default:  next_state = S_FETCH;
        endcase
    end

    // Every instruction ends in exactly one cycle whose successor is FETCH.
    assign pc_step = (state != S_FETCH) && (next_state == S_FETCH);
    assign taken   = is_jump || (is_branch && zero_flag);

    always_comb begin
        inst_ready = 1'b0;
        wr_en      = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        pc_inc     = 1'b0;
        en_pc_2    = 1'b0;
        branch_en  = 1'b0;
        err        = 1'b0;
        src_reg    = '0;
        dst_reg    = '0;
        wr_reg     = '0;
        alu_op     = '0;
        pc_offset  = '0;
        fsm_state  = '0;
        if (!rst) begin
            inst_ready = (state == S_FETCH) && !stall;
            wr_en      = (state == S_WB);
            mem_rd     = (state == S_MEMW) && is_load;
            mem_wr     = (state == S_MEMW) && is_store;
            pc_inc     = pc_step;
            branch_en  = pc_step && taken;
            en_pc_2    = pc_step && !taken;
            err        = timeout;
            dst_reg    = ir[INST_W-OPC_W-1 -: REG_AW];
            src_reg    = ir[INST_W-OPC_W-REG_AW-1 -: REG_AW];
            wr_reg     = ir[INST_W-OPC_W-1 -: REG_AW];
            alu_op     = is_alu ? ALU_OP_W'(opc) : '0;
            pc_offset  = ir[OFFS_W-1:0];
            fsm_state  = state;
        end
    end

endmodule
